// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus interconnect: FSM state type,
// byte-strobe width derivation, index-width helper and the default SoC
// address map (RAM, LEDS, UART, TIMER).
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE    = 2'd0,
    BUS_ACCESS  = 2'd1,
    BUS_RESPOND = 2'd2
  } bus_state_t;

  // One byte enable per data byte.
  function automatic int unsigned bus_strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Width of an index register for n items; never narrower than one bit.
  function automatic int unsigned bus_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam logic [63:0] BUS_RAM_BASE   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] BUS_LEDS_BASE  = 64'h0000_0000_0001_0000;
  localparam logic [63:0] BUS_UART_BASE  = 64'h0000_0000_0002_0000;
  localparam logic [63:0] BUS_TIMER_BASE = 64'h0000_0000_0003_0000;

  localparam logic [63:0] BUS_RAM_MASK   = 64'hFFFF_FFFF_FFFF_0000;
  localparam logic [63:0] BUS_LEDS_MASK  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] BUS_UART_MASK  = 64'hFFFF_FFFF_FFFF_FFF0;
  localparam logic [63:0] BUS_TIMER_MASK = 64'hFFFF_FFFF_FFFF_FFF0;

endpackage

// File: rtl/bus_xbar_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// after the last-granted index, wrapping around. The pointer register
// is owned by the instantiating block.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = bus_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  // Scan N positions starting just after the last grant; first hit wins.
  always_comb begin
    int unsigned c;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    c         = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(last) + k) % N;
      if (!any_grant && req[c]) begin
        any_grant = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/bus_xbar.sv
// Multi-master / multi-slave memory-bus interconnect. Round-robin
// arbitration, base/mask decode (lowest slave index wins on overlap),
// per-slave wait states and an error response for unmapped accesses.
// Optional ACCESS watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_xbar
  import bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = 2,
  parameter  int unsigned NUM_SLAVES     = 4,
  parameter  int unsigned ADDR_W         = 64,
  parameter  int unsigned DATA_W         = 64,
  parameter  logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {BUS_TIMER_BASE, BUS_UART_BASE, BUS_LEDS_BASE, BUS_RAM_BASE},
  parameter  logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {BUS_TIMER_MASK, BUS_UART_MASK, BUS_LEDS_MASK, BUS_RAM_MASK},
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned STRB_W         = bus_strb_w(DATA_W),
  localparam int unsigned MIDX_W         = bus_idx_w(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]        m_read_in,
  input  logic [NUM_MASTERS-1:0]        m_write_in,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_write_mask_in,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_write_value_in,
  output logic [NUM_MASTERS*DATA_W-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]        m_ready_out,
  output logic [NUM_MASTERS-1:0]        m_error_out,
  output logic [ADDR_W-1:0]             s_address_out,
  output logic                          s_read_out,
  output logic                          s_write_out,
  output logic [STRB_W-1:0]             s_write_mask_out,
  output logic [DATA_W-1:0]             s_write_value_out,
  output logic [NUM_SLAVES-1:0]         s_sel_out,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_read_value_in,
  input  logic [NUM_SLAVES-1:0]         s_ready_in
);

  bus_state_t              state;
  logic [MIDX_W-1:0]       rr_ptr;
  logic [MIDX_W-1:0]       grant_idx;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;

  logic [NUM_MASTERS-1:0]  req;
  logic [NUM_MASTERS-1:0]  arb_grant;
  logic [MIDX_W-1:0]       arb_idx;
  logic                    arb_any;

  logic [ADDR_W-1:0]       g_addr;
  logic                    g_rd;
  logic                    g_wr;
  logic [STRB_W-1:0]       g_mask;
  logic [DATA_W-1:0]       g_wdata;

  logic [NUM_SLAVES-1:0]   hit_sel;
  logic                    hit_any;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_data;
  logic                    timed_out;

  assign req = m_read_in | m_write_in;

  rr_arbiter #(.N(NUM_MASTERS)) u_arb (
    .req       (req),
    .last      (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  // AND-OR mux of the granted master's request fields.
  always_comb begin
    g_addr  = '0;
    g_rd    = 1'b0;
    g_wr    = 1'b0;
    g_mask  = '0;
    g_wdata = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (arb_grant[m]) begin
        g_addr  = g_addr  | m_address_in[m*ADDR_W +: ADDR_W];
        g_rd    = g_rd    | m_read_in[m];
        g_wr    = g_wr    | m_write_in[m];
        g_mask  = g_mask  | m_write_mask_in[m*STRB_W +: STRB_W];
        g_wdata = g_wdata | m_write_value_in[m*DATA_W +: DATA_W];
      end
    end
  end

  // Base/mask decode of the granted address; lowest matching slave wins.
  always_comb begin
    hit_sel = '0;
    hit_any = 1'b0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (!hit_any &&
          ((g_addr & SLAVE_MASK[s*ADDR_W +: ADDR_W]) == SLAVE_BASE[s*ADDR_W +: ADDR_W])) begin
        hit_any    = 1'b1;
        hit_sel[s] = 1'b1;
      end
    end
  end

  // Ready and read data of the currently selected slave.
  always_comb begin
    sel_ready = |(s_ready_in & s_sel_out);
    sel_data  = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (s_sel_out[s]) sel_data = sel_data | s_read_value_in[s*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO_W = bus_idx_w(TIMEOUT_CYCLES);
  logic [TO_W-1:0] wait_cnt;

  assign timed_out = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: zero outside ACCESS, counts every ACCESS cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   wait_cnt <= '0;
    else if (state != BUS_ACCESS) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

  // Transaction FSM: grant/decode in IDLE, hold in ACCESS, pulse in RESPOND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= BUS_IDLE;
      rr_ptr            <= MIDX_W'(NUM_MASTERS - 1);
      grant_idx         <= '0;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      s_address_out     <= '0;
      s_read_out        <= 1'b0;
      s_write_out       <= 1'b0;
      s_write_mask_out  <= '0;
      s_write_value_out <= '0;
      s_sel_out         <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (arb_any) begin
            grant_idx         <= arb_idx;
            s_address_out     <= g_addr;
            s_write_value_out <= g_wdata;
            if (hit_any) begin
              s_sel_out        <= hit_sel;
              s_read_out       <= g_rd;
              s_write_out      <= g_wr;
              s_write_mask_out <= g_wr ? g_mask : '0;
              rsp_err          <= 1'b0;
              state            <= BUS_ACCESS;
            end else begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
              state    <= BUS_RESPOND;
            end
          end
        end
        BUS_ACCESS: begin
          if (sel_ready || timed_out) begin
            rsp_data         <= (sel_ready && s_read_out) ? sel_data : '0;
            rsp_err          <= !sel_ready;
            s_sel_out        <= '0;
            s_read_out       <= 1'b0;
            s_write_out      <= 1'b0;
            s_write_mask_out <= '0;
            state            <= BUS_RESPOND;
          end
        end
        BUS_RESPOND: begin
          rr_ptr <= grant_idx;
          state  <= BUS_IDLE;
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

  // Route the one-cycle response to the granted master only.
  always_comb begin
    m_ready_out      = '0;
    m_error_out      = '0;
    m_read_value_out = '0;
    if (state == BUS_RESPOND) begin
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        if (MIDX_W'(m) == grant_idx) begin
          m_ready_out[m]                        = 1'b1;
          m_error_out[m]                        = rsp_err;
          m_read_value_out[m*DATA_W +: DATA_W]  = rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_xbar.sv
// Self-checking bench for bus_xbar (2 masters, 4 slaves, default map).
// Honours BUS_TIMEOUT_EN to select the watchdog expectations.
module tb_bus_xbar;

`ifdef BUS_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [127:0] m_address_in;
  logic [1:0]   m_read_in;
  logic [1:0]   m_write_in;
  logic [15:0]  m_write_mask_in;
  logic [127:0] m_write_value_in;
  logic [127:0] m_read_value_out;
  logic [1:0]   m_ready_out;
  logic [1:0]   m_error_out;
  logic [63:0]  s_address_out;
  logic         s_read_out;
  logic         s_write_out;
  logic [7:0]   s_write_mask_out;
  logic [63:0]  s_write_value_out;
  logic [3:0]   s_sel_out;
  logic [255:0] s_read_value_in;
  logic [3:0]   s_ready_in;

  bus_xbar #(
    .NUM_MASTERS    (2),
    .NUM_SLAVES     (4),
    .ADDR_W         (64),
    .DATA_W         (64),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .m_address_in      (m_address_in),
    .m_read_in         (m_read_in),
    .m_write_in        (m_write_in),
    .m_write_mask_in   (m_write_mask_in),
    .m_write_value_in  (m_write_value_in),
    .m_read_value_out  (m_read_value_out),
    .m_ready_out       (m_ready_out),
    .m_error_out       (m_error_out),
    .s_address_out     (s_address_out),
    .s_read_out        (s_read_out),
    .s_write_out       (s_write_out),
    .s_write_mask_out  (s_write_mask_out),
    .s_write_value_out (s_write_value_out),
    .s_sel_out         (s_sel_out),
    .s_read_value_in   (s_read_value_in),
    .s_ready_in        (s_ready_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_err;

  // Per-master request fields and per-slave behaviour.
  logic [63:0] a   [2];
  logic        rd  [2];
  logic        wr  [2];
  logic [7:0]  msk [2];
  logic [63:0] wv  [2];
  int          w   [4];
  logic [63:0] sd  [4];
  int          acc_cnt;
  int          last;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address map as plain ranges.
  function automatic int region_of(input logic [63:0] ad);
    if (ad < 64'h1_0000)                       return 0;
    if (ad >= 64'h1_0000 && ad < 64'h1_0004)   return 1;
    if (ad >= 64'h2_0000 && ad < 64'h2_0010)   return 2;
    if (ad >= 64'h3_0000 && ad < 64'h3_0010)   return 3;
    return -1;
  endfunction

  // Next requester after the last one served, wrapping.
  function automatic int pick(input logic [1:0] req);
    for (int off = 1; off <= 2; off++) begin
      if (req[(last + off) % 2]) return (last + off) % 2;
    end
    return -1;
  endfunction

  // Slave model: ready after w[j] wait cycles of continuous selection.
  task automatic slave_update();
    for (int j = 0; j < 4; j++) s_read_value_in[j*64 +: 64] = sd[j];
    s_ready_in = '0;
    if (s_sel_out == '0) acc_cnt = 0;
    else begin
      for (int j = 0; j < 4; j++)
        if (s_sel_out[j] && acc_cnt == w[j]) s_ready_in[j] = 1'b1;
      acc_cnt++;
    end
  endtask

  // Advance one clock; slaves react 1 ns after the edge, checks at +4 ns.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    slave_update();
    #3;
  endtask

  task automatic run_txn(input logic [1:0] req);
    int g, h, lat;
    logic err, to;
    logic [63:0]  data;
    logic [1:0]   exp_oh;
    logic [127:0] exp_rv;
    for (int m = 0; m < 2; m++) begin
      m_address_in[m*64 +: 64]     = a[m];
      m_read_in[m]                 = req[m] & rd[m];
      m_write_in[m]                = req[m] & wr[m];
      m_write_mask_in[m*8 +: 8]    = msk[m];
      m_write_value_in[m*64 +: 64] = wv[m];
    end
    g  = pick(req);
    h  = region_of(a[g]);
    to = 1'b0;
    if (h < 0) begin
      lat = 1; err = 1'b1; data = '0;
    end else if (TO_EN && w[h] >= TO) begin
      lat = TO + 1; err = 1'b1; data = '0; to = 1'b1;
    end else begin
      lat = 2 + w[h]; err = 1'b0; data = rd[g] ? sd[h] : 64'h0;
    end
    exp_oh = 2'b01 << g;
    exp_rv = '0;
    exp_rv[g*64 +: 64] = data;
    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      if (k < lat) begin
        chk("rdy_early", m_ready_out, 0);
        chk("sel_hold", s_sel_out, 4'b0001 << h);
        if (k == 1) begin
          chk("s_addr", s_address_out, a[g]);
          chk("s_strobe", {s_read_out, s_write_out}, {rd[g], wr[g]});
          chk("s_mask", s_write_mask_out, wr[g] ? msk[g] : 8'h00);
          chk("s_wdata", s_write_value_out, wv[g]);
        end
      end else begin
        chk("rdy", m_ready_out, exp_oh);
        chk("err", m_error_out, err ? exp_oh : 2'b00);
        chk("rdata", m_read_value_out, exp_rv);
        if (h < 0 || to) chk("sel_rsp", s_sel_out, 0);
      end
    end
    m_read_in  = '0;
    m_write_in = '0;
    last       = g;
    next_cycle();
  endtask

  task automatic gen_rand();
    for (int m = 0; m < 2; m++) begin
      case ($urandom % 6)
        0:       a[m] = 64'($urandom % 32'h1_0000);
        1:       a[m] = 64'h1_0000 + 64'($urandom % 4);
        2:       a[m] = 64'h2_0000 + 64'($urandom % 16);
        3:       a[m] = 64'h3_0000 + 64'($urandom % 16);
        4:       a[m] = 64'h1_0004 + 64'($urandom % 32'hFFFC);
        default: a[m] = {$urandom_range(255, 1), $urandom};
      endcase
      rd[m]  = 1'($urandom % 2);
      wr[m]  = ~rd[m];
      msk[m] = 8'($urandom);
      wv[m]  = {$urandom, $urandom};
    end
    for (int j = 0; j < 4; j++) begin
      w[j]  = int'($urandom % 4);
      if (TO_EN && ($urandom % 8 == 0)) w[j] = 20;
      sd[j] = {$urandom, $urandom};
    end
  endtask

  initial begin
    logic seen;
    logic [1:0] exp_f;
    n_vec = 0; n_err = 0; acc_cnt = 0; last = 1;
    m_address_in = '0; m_read_in = '0; m_write_in = '0;
    m_write_mask_in = '0; m_write_value_in = '0;
    s_read_value_in = '0; s_ready_in = '0;
    for (int j = 0; j < 4; j++) begin w[j] = 0; sd[j] = '0; end
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_ctl", {m_ready_out, m_error_out, s_read_out, s_write_out, s_sel_out, s_write_mask_out}, 0);
    chk("rst_addr", s_address_out, 0);
    next_cycle();
    next_cycle();
    reset = 1'b1;

    // Fairness from reset: both masters read RAM continuously.
    m_address_in = {64'h200, 64'h100};
    m_read_in    = 2'b11;
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      exp_f = (k % 3 == 2) ? (2'b01 << ((k / 3) % 2)) : 2'b00;
      chk("fair", m_ready_out, exp_f);
    end
    m_read_in = '0;
    last = 1;
    next_cycle();

    // Single read from RAM.
    a[0] = 64'h10; rd[0] = 1'b1; wr[0] = 1'b0; msk[0] = 8'hFF; wv[0] = 64'h0;
    w[0] = 0; sd[0] = 64'hDEAD_BEEF;
    run_txn(2'b01);

    // Write to LEDS with three wait cycles.
    a[1] = 64'h1_0000; rd[1] = 1'b0; wr[1] = 1'b1; msk[1] = 8'h01; wv[1] = 64'h1234;
    w[1] = 3;
    run_txn(2'b10);

    // Unmapped read.
    a[0] = 64'h5_0000; rd[0] = 1'b1; wr[0] = 1'b0;
    run_txn(2'b01);

    // UART that never answers (watchdog fires when enabled).
    if (TO_EN) begin
      a[0] = 64'h2_0000; rd[0] = 1'b1; wr[0] = 1'b0; w[2] = 1000000;
      run_txn(2'b01);
    end

    // Stalled access, then reset in the middle of it.
    a[0] = 64'h2_0004; w[2] = 1000000;
    m_address_in[63:0] = a[0];
    m_read_in = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < (TO_EN ? 5 : 1000); i++) begin
      next_cycle();
      seen = seen | (|m_ready_out);
    end
    chk("stall_no_rdy", seen, 0);
    chk("stall_sel", s_sel_out, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("arst_ctl", {m_ready_out, m_error_out, s_read_out, s_write_out, s_sel_out, s_write_mask_out}, 0);
    chk("arst_addr", s_address_out, 0);
    chk("arst_vals", {s_write_value_out, m_read_value_out}, 0);
    m_read_in = '0;
    next_cycle();
    reset = 1'b1;
    last = 1;
    next_cycle();

    // After reset master 0 has first priority.
    a[0] = 64'h3_0004; a[1] = 64'h2_0008;
    rd[0] = 1'b1; wr[0] = 1'b0; rd[1] = 1'b1; wr[1] = 1'b0;
    for (int j = 0; j < 4; j++) w[j] = 0;
    sd[3] = 64'h0123_4567_89AB_CDEF;
    run_txn(2'b11);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      gen_rand();
      run_txn(2'($urandom_range(3, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_xbar.md
# bus_xbar

Parametrised multi-master, multi-slave memory-bus interconnect for the SoC. It replaces the fixed two-port arbiter and the hard-coded address decode with a single block that provides:

- round-robin arbitration across `NUM_MASTERS` requesters;
- base/mask decode onto `NUM_SLAVES` targets;
- slave wait-state support via per-slave ready;
- an error response for unmapped or stalled accesses.

It sits between the CPU instruction/data ports (plus any future DMA) and the RAM, LED, UART and timer peripherals.

## Interface
Parameters:
- `NUM_MASTERS`, 2: requesting ports, 1..8.
- `NUM_SLAVES`, 4: target regions, 1..16.
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width. `STRB_W` = `DATA_W`/8.
- `SLAVE_BASE`, {RAM 0x0, LEDS 0x10000, UART 0x20000, TIMER 0x30000}: concatenated `NUM_SLAVES`×`ADDR_W` bases; slave 0 in the LSBs.
- `SLAVE_MASK`, {0xFFFF…0000, 0xFFFF…FFFC, 0xFFFF…FFF0, 0xFFFF…FFF0}: concatenated decode masks.
- `TIMEOUT_CYCLES`, 255: ACCESS-state cycle limit. Only meaningful with `BUS_TIMEOUT_EN`.

Ports:
- `clk` input 1: system clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `m_address_in` input `NUM_MASTERS`×`ADDR_W`: per-master address.
- `m_read_in` input `NUM_MASTERS`: per-master read request.
- `m_write_in` input `NUM_MASTERS`: per-master write request.
- `m_write_mask_in` input `NUM_MASTERS`×`STRB_W`: byte enables.
- `m_write_value_in` input `NUM_MASTERS`×`DATA_W`: write data.
- `m_read_value_out` output `NUM_MASTERS`×`DATA_W`: read data. Valid only with ready.
- `m_ready_out` output `NUM_MASTERS`: one-cycle completion pulse.
- `m_error_out` output `NUM_MASTERS`: error flag. Valid only with ready.
- `s_address_out` output `ADDR_W`: shared slave address.
- `s_read_out` output 1: shared slave read strobe.
- `s_write_out` output 1: shared slave write strobe.
- `s_write_mask_out` output `STRB_W`: shared byte enables. Forced to 0 for reads.
- `s_write_value_out` output `DATA_W`: shared write data.
- `s_sel_out` output `NUM_SLAVES`: one-hot slave select.
- `s_read_value_in` input `NUM_SLAVES`×`DATA_W`: per-slave read data.
- `s_ready_in` input `NUM_SLAVES`: per-slave ready.

## Operation
- State machine has three states: IDLE → ACCESS → RESPOND → IDLE.
- **IDLE**
  - A master requests when `m_read_in | m_write_in` is high.
  - The round-robin arbiter grants the first requesting master after the last granted one.
  - On grant, latch the master index, address, read, write, mask and data into the slave-side output registers.
  - Decode: a slave hits when `(addr & MASK) == BASE`. On overlapping hits, the lowest slave index wins.
  - Hit → ACCESS, with `s_sel_out` one-hot set. Miss → RESPOND with the error flag set and no slave selected.
- **ACCESS**
  - `s_sel_out` and the slave-side signals are held stable.
  - When `s_ready_in[sel]` is high, capture `s_read_value_in[sel]` (0 for writes) and go to RESPOND.
- **RESPOND**
  - Assert `m_ready_out[grant]` for exactly one cycle, together with the captured data and error flag.
  - All other masters see ready 0 and read value 0.
  - Advance the round-robin pointer to the grant index, then go to IDLE.
- Masters hold their request stable until ready. A request still asserted in the cycle after ready is treated as a new transaction.
- If read and write are both high, both strobes are forwarded. The slave defines the result.
- A request that drops before grant is simply not granted. Dropping after grant is illegal, but the transaction still completes.

## Timing
- Reset values: state IDLE, RR pointer = `NUM_MASTERS`−1 (master 0 is first priority), and all outputs 0.
- Reset asserted mid-transaction aborts the transaction immediately. No ready is issued.
- Minimum latency: request sampled in cycle 0 → ACCESS in cycle 1 (slave ready same cycle) → `m_ready_out` in cycle 2.
- Each slave wait cycle adds one cycle of latency.
- Unmapped access: ready with error in cycle 1.
- Bus throughput is at most one transaction per 3 cycles.
- Back-to-back: if both masters request continuously, grants alternate 0,1,0,1.

## Configuration
- `BUS_TIMEOUT_EN`:
  - Defined: a counter, cleared on entry to ACCESS, increments each ACCESS cycle. Reaching `TIMEOUT_CYCLES` without slave ready → RESPOND with error 1 and read value 0; `s_sel_out` drops.
  - Undefined: ACCESS waits indefinitely. Error is raised only for unmapped addresses. The counter logic is absent.

## Structure
- Shared package `bus_pkg` holds:
  - the state enum `{BUS_IDLE, BUS_ACCESS, BUS_RESPOND}`;
  - the `STRB_W` derivation;
  - default address-map constants for RAM/LEDS/UART/TIMER.
- Sub-module `rr_arbiter` (parametrised on N):
  - inputs: request vector, last-grant pointer;
  - outputs: one-hot grant, grant index, any-grant;
  - purely combinational. The pointer register lives in `bus_xbar`.

## Test plan
- **Single read:** M0 reads 0x0000_0010, RAM ready immediately with 0xDEAD_BEEF → `m_ready_out[0]` in cycle 2, data 0xDEAD_BEEF, error 0.
- **Write with stall:** M1 writes 0x1234 to 0x1_0000 with mask 0x01, LEDS ready after 3 wait cycles → `s_sel_out`=0b0010 for 4 cycles, `s_write_mask_out`=0x01, ready in cycle 5.
- **Fairness:** M0 and M1 request continuously from reset → grants 0,1,0,1, one transaction every 3 cycles.
- **Unmapped:** read from 0x5_0000 → `s_sel_out` stays 0, ready with error 1 in cycle 1, data 0.
- **Timeout (`BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8):** UART never ready → error 1 and ready after 8 ACCESS cycles. Without the macro, no ready after 1000 cycles.
- **Reset mid-ACCESS:** assert `reset` low during a stalled access → all outputs 0 asynchronously. After release, M0 holds first priority.
